carry_select_pipe: RTL and testbench

CARRY_SELECT_PIPE -- requirements
Module: carry_select_pipe

---
 rtl/csel_pkg.sv | 6 +
 rtl/csel_block.sv | 33 +++
 rtl/carry_select_pipe.sv | 160 ++++++++++++++++
 tb/tb_carry_select_pipe.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csel_pkg.sv
// Shared defaults for the carry-select adder pipeline.
package csel_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int BLOCK_DEF = 4;
  localparam int NBLK      = WIDTH_DEF / BLOCK_DEF;
endpackage

// File: rtl/csel_block.sv
// One BLOCK-bit ripple adder that produces both carry-in-0 and carry-in-1 results.
module csel_block
  import csel_pkg::*;
#(
  parameter int BLOCK = BLOCK_DEF
) (
  input  logic [BLOCK-1:0] a_i,
  input  logic [BLOCK-1:0] b_i,
  output logic [BLOCK-1:0] sum0_o,
  output logic [BLOCK-1:0] sum1_o,
  output logic             c0_o,
  output logic             c1_o
);

  logic rc0;
  logic rc1;

  always_comb begin
    sum0_o = '0;
    sum1_o = '0;
    rc0    = 1'b0;
    rc1    = 1'b1;
    for (int i = 0; i < BLOCK; i++) begin
      sum0_o[i] = a_i[i] ^ b_i[i] ^ rc0;
      sum1_o[i] = a_i[i] ^ b_i[i] ^ rc1;
      rc0       = (a_i[i] & b_i[i]) | (rc0 & (a_i[i] ^ b_i[i]));
      rc1       = (a_i[i] & b_i[i]) | (rc1 & (a_i[i] ^ b_i[i]));
    end
    c0_o = rc0;
    c1_o = rc1;
  end

endmodule

// File: rtl/carry_select_pipe.sv
// Two-stage carry-select add/subtract pipeline with valid/ready handshakes.
// Optional signed-overflow output is enabled by defining CSEL_OVF_EN.
module carry_select_pipe
  import csel_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int BLOCK = BLOCK_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             carry,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef CSEL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NB = WIDTH / BLOCK;

  logic [WIDTH-1:0] ye;
  logic             ce;
  logic             in_fire;
  logic             s2_load;

  logic [BLOCK-1:0] lo_sum_d;
  logic             lo_c_d;
  logic [BLOCK-1:0] sum0_d [1:NB-1];
  logic [BLOCK-1:0] sum1_d [1:NB-1];
  logic             c0_d   [1:NB-1];
  logic             c1_d   [1:NB-1];

  logic             s1_valid_q;
  logic [BLOCK-1:0] s1_lo_sum_q;
  logic             s1_lo_c_q;
  logic [BLOCK-1:0] s1_sum0_q [1:NB-1];
  logic [BLOCK-1:0] s1_sum1_q [1:NB-1];
  logic             s1_c0_q   [1:NB-1];
  logic             s1_c1_q   [1:NB-1];

  logic             out_valid_q;
  logic [WIDTH-1:0] s_d,    s_q;
  logic             cout_d, cout_q;
  logic             blk_c;

  assign ye       = sub ? ~y : y;
  assign ce       = sub ? ~carry : carry;
  assign in_ready = !s1_valid_q || !out_valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);

  assign {lo_c_d, lo_sum_d} = {1'b0, x[BLOCK-1:0]} + {1'b0, ye[BLOCK-1:0]} + {{BLOCK{1'b0}}, ce};

  for (genvar b = 1; b < NB; b++) begin : g_blk
    csel_block #(.BLOCK(BLOCK)) u_blk (
      .a_i    (x[b*BLOCK +: BLOCK]),
      .b_i    (ye[b*BLOCK +: BLOCK]),
      .sum0_o (sum0_d[b]),
      .sum1_o (sum1_d[b]),
      .c0_o   (c0_d[b]),
      .c1_o   (c1_d[b])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_lo_sum_q <= '0;
      s1_lo_c_q   <= 1'b0;
      for (int b = 1; b < NB; b++) begin
        s1_sum0_q[b] <= '0;
        s1_sum1_q[b] <= '0;
        s1_c0_q[b]   <= 1'b0;
        s1_c1_q[b]   <= 1'b0;
      end
    end else begin
      if (in_fire) begin
        s1_valid_q  <= 1'b1;
        s1_lo_sum_q <= lo_sum_d;
        s1_lo_c_q   <= lo_c_d;
        for (int b = 1; b < NB; b++) begin
          s1_sum0_q[b] <= sum0_d[b];
          s1_sum1_q[b] <= sum1_d[b];
          s1_c0_q[b]   <= c0_d[b];
          s1_c1_q[b]   <= c1_d[b];
        end
      end else if (s2_load) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  // Resolve block carries lowest to highest, picking each precomputed candidate.
  always_comb begin
    s_d              = '0;
    blk_c            = s1_lo_c_q;
    s_d[BLOCK-1:0]   = s1_lo_sum_q;
    for (int b = 1; b < NB; b++) begin
      s_d[b*BLOCK +: BLOCK] = blk_c ? s1_sum1_q[b] : s1_sum0_q[b];
      blk_c                 = blk_c ? s1_c1_q[b]   : s1_c0_q[b];
    end
    cout_d = blk_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      cout_q      <= 1'b0;
    end else if (s2_load) begin
      out_valid_q <= 1'b1;
      s_q         <= s_d;
      cout_q      <= cout_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign cout      = cout_q;

`ifdef CSEL_OVF_EN
  // Carry into the MSB is recovered as x ^ ye ^ sum at that bit position.
  logic s1_msb_x_q;
  logic s1_msb_ye_q;
  logic ovf_d, ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_msb_x_q  <= 1'b0;
      s1_msb_ye_q <= 1'b0;
    end else if (in_fire) begin
      s1_msb_x_q  <= x[WIDTH-1];
      s1_msb_ye_q <= ye[WIDTH-1];
    end
  end

  assign ovf_d = s1_msb_x_q ^ s1_msb_ye_q ^ s_d[WIDTH-1] ^ cout_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (s2_load) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_carry_select_pipe.sv
// Self-checking bench for carry_select_pipe against an arithmetic reference model.
module tb_carry_select_pipe;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         carry = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf_obs;

`ifdef CSEL_OVF_EN
  logic ovf;
  assign ovf_obs = ovf;
`else
  assign ovf_obs = 1'b0;
`endif

  carry_select_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .carry     (carry),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout)
`ifdef CSEL_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {ovf, cout, s} from plain integer arithmetic.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic c, input logic sb);
    int ue, uc, usum, sa, sbv, ssum;
    logic [9:0] r;
    ue   = sb ? (255 - int'(b)) : int'(b);
    uc   = sb ? (c ? 0 : 1) : (c ? 1 : 0);
    usum = int'(a) + ue + uc;
    sa   = (a >= 8'd128) ? int'(a) - 256 : int'(a);
    sbv  = (ue >= 128) ? ue - 256 : ue;
    ssum = sa + sbv + uc;
    r[7:0] = usum[7:0];
    r[8]   = (usum >= 256);
    r[9]   = (ssum > 127) || (ssum < -128);
    return r;
  endfunction

  logic [9:0] exp_q[$];
  logic       stall_q = 1'b0;
  logic [9:0] held;
  int         out_cnt = 0;

  always @(negedge clk) begin
    logic [9:0] e;
    if (!rst_n) begin
      exp_q.delete();
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", {ovf_obs, cout, s}, held);
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("s", s, e[7:0]);
          check("cout", cout, e[8]);
`ifdef CSEL_OVF_EN
          check("ovf", ovf_obs, e[9]);
`endif
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(x, y, carry, sub));
      stall_q = out_valid && !out_ready;
      held    = {ovf_obs, cout, s};
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c, input logic sb);
    int t;
    t = 0;
    x = a; y = b; carry = c; sub = sb; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_and_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                                input logic c, input logic sb,
                                input logic [7:0] es, input logic ec, input logic eo);
    int t;
    send(a, b, c, sb);
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_s"}, s, es);
    check({tag, "_cout"}, cout, ec);
`ifdef CSEL_OVF_EN
    check({tag, "_ovf"}, ovf_obs, eo);
`else
    if (eo === 1'bx) check({tag, "_ovf"}, ovf_obs, 0);
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

  initial begin
    int acc, seen, run, starts, c0;
    logic pv;
    logic [7:0] h;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_s", s, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf_obs, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Basic add and two-cycle latency
    out_ready = 1'b1;
    send(8'h01, 8'h06, 1'b0, 1'b0);
    @(negedge clk);
    check("lat_cycle1", out_valid, 0);
    @(negedge clk);
    check("lat_cycle2", out_valid, 1);
    check("basic_s", s, 8'h07);
    check("basic_cout", cout, 0);
    @(posedge clk);
    #1;

    // Carry ripple, overflow and subtract corners
    send_and_check("ripple", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    send_and_check("ovf_add", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    send_and_check("sub_neg", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    send_and_check("sub_brw", 8'h09, 8'h02, 1'b1, 1'b1, 8'h06, 1'b1, 1'b0);
    send_and_check("ovf_sub", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Back-pressure: three offered, two accepted
    out_ready = 1'b0;
    acc = 0;
    c0 = out_cnt;
    for (int i = 0; i < 3; i++) begin
      x = 8'h10 + 8'(i); y = 8'(i * 3); carry = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) acc++;
      if (i == 2) check("bp_ready_third", in_ready, 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("bp_accepted", acc, 2);
    @(negedge clk);
    h = s;
    repeat (4) @(negedge clk);
    check("bp_s_stable", s, h);
    check("bp_ready_full", in_ready, 0);
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("bp_drained", exp_q.size(), 0);
    check("bp_count", out_cnt - c0, 2);
    @(posedge clk);
    #1;

    // Reset with both stages full
    out_ready = 1'b0;
    send(8'h33, 8'h44, 1'b0, 1'b0);
    send(8'h55, 8'h11, 1'b1, 1'b1);
    @(negedge clk);
    check("rs_full_valid", out_valid, 1);
    check("rs_full_ready", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rs_out_valid", out_valid, 0);
    check("rs_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rs_no_stale", seen, 0);
    @(posedge clk);
    #1;

    // Throughput: 16 back-to-back operations
    run = 0; starts = 0; pv = 1'b0;
    for (int i = 0; i < 16; i++) begin
      x = 8'($urandom); y = 8'($urandom); carry = 1'($urandom); sub = 1'($urandom);
      in_valid = 1'b1;
      @(negedge clk);
      check("tp_ready", in_ready, 1);
      if (out_valid) begin run++; if (!pv) starts++; end
      pv = out_valid;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) begin run++; if (!pv) starts++; end
      pv = out_valid;
    end
    check("tp_results", run, 16);
    check("tp_one_burst", starts, 1);
    @(posedge clk);
    #1;

    // Random traffic with random back-pressure
    for (int i = 0; i < 300; i++) begin
      x = 8'($urandom); y = 8'($urandom); carry = 1'($urandom); sub = 1'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("rand_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
